// File: rtl/spi_slave_wb.sv
// spi_slave_wb: SPI responder with an 8-bit Wishbone register interface.
//
// A local Wishbone host preloads transmit bytes and collects received bytes
// while an external SPI master clocks full-duplex, MSB-first byte transfers.
// SPI pins are asynchronous and are oversampled in the wb_clk_i domain.
//
// Ports:
//   wb_clk_i, wb_rst_i      system clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i      Wishbone cycle / strobe
//   wb_adr_i[1:0]           0 RXDATA(RO) 1 TXDATA(WO) 2 STATUS 3 CTRL
//   wb_we_i, wb_dat_i[7:0]  write enable / write data
//   wb_dat_o[7:0], wb_ack_o read data (valid in ack cycle) / acknowledge
//   inta_o                  interrupt, active high, registered
//   sck_i, ss_n_i, mosi_i   SPI inputs from the master (asynchronous)
//   miso_o, miso_oe         SPI data out and its tristate enable
module spi_slave_wb (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic [1:0] wb_adr_i,
    input  logic       wb_we_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic       inta_o,
    input  logic       sck_i,
    input  logic       ss_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe
);

    localparam logic [1:0] ADR_RXDATA = 2'd0;
    localparam logic [1:0] ADR_TXDATA = 2'd1;
    localparam logic [1:0] ADR_STATUS = 2'd2;
    localparam logic [1:0] ADR_CTRL   = 2'd3;

    // Synchronizer idle pattern {mosi, ss_n, sck}: slave deselected, sck low.
    localparam logic [2:0] SYNC_IDLE = 3'b010;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t     state_reg;
    logic [2:0] sync1_reg, sync2_reg;
    logic       sck_d_reg, ss_d_reg;
    logic [7:0] rxdata_reg, txdata_reg, rx_shift_reg, tx_shift_reg;
    logic       rx_full_reg, tx_full_reg, overrun_reg, underrun_reg;
    logic       cpha_reg, cpol_reg, en_reg, rx_ie_reg, tx_ie_reg;
    logic [2:0] bit_cnt_reg;
    logic       load_pending_reg;

    logic       sck_s, ss_s, mosi_s;
    logic       lead_edge, trail_edge, sample_edge, shift_edge, ss_fall;
    logic       frame_ok, start, byte_done, tx_load;
    logic       wb_req, rd_rx, wr_tx, wr_status, wr_ctrl;
    logic [7:0] rx_byte, tx_src, status_val, ctrl_val, rd_val;
    logic       unused_bits;

    assign sck_s  = sync2_reg[0];
    assign ss_s   = sync2_reg[1];
    assign mosi_s = sync2_reg[2];

    // Leading edge leaves the idle level cpol, trailing edge returns to it.
    assign lead_edge   = (sck_s != cpol_reg) && (sck_d_reg == cpol_reg);
    assign trail_edge  = (sck_s == cpol_reg) && (sck_d_reg != cpol_reg);
    assign sample_edge = cpha_reg ? trail_edge : lead_edge;
    assign shift_edge  = cpha_reg ? lead_edge  : trail_edge;
    assign ss_fall     = !ss_s && ss_d_reg;

    assign frame_ok  = (state_reg == ST_ACTIVE) && en_reg && !ss_s;
    assign start     = (state_reg == ST_IDLE) && en_reg && ss_fall;
    assign byte_done = frame_ok && sample_edge && (bit_cnt_reg == 3'd7);
    // A fresh tx byte is taken at selection and at the first shift edge
    // following a completed byte.
    assign tx_load   = start || (frame_ok && shift_edge && load_pending_reg);

    assign rx_byte = {rx_shift_reg[6:0], mosi_s};
    assign tx_src  = tx_full_reg ? txdata_reg : 8'hFF;

    // Ack is issued every other cycle of a held strobe.
    assign wb_req    = wb_cyc_i && wb_stb_i && !wb_ack_o;
    assign rd_rx     = wb_req && !wb_we_i && (wb_adr_i == ADR_RXDATA);
    assign wr_tx     = wb_req &&  wb_we_i && (wb_adr_i == ADR_TXDATA);
    assign wr_status = wb_req &&  wb_we_i && (wb_adr_i == ADR_STATUS);
    assign wr_ctrl   = wb_req &&  wb_we_i && (wb_adr_i == ADR_CTRL);

    assign status_val = {3'b000, state_reg == ST_ACTIVE, underrun_reg,
                         overrun_reg, tx_full_reg, rx_full_reg};
    assign ctrl_val   = {3'b000, tx_ie_reg, rx_ie_reg, en_reg, cpol_reg, cpha_reg};

    assign unused_bits = &{1'b0, wb_dat_i[7:5], rx_shift_reg[7]};

    always_comb begin
        rd_val = 8'h00;
        case (wb_adr_i)
            ADR_RXDATA: rd_val = rxdata_reg;
            ADR_STATUS: rd_val = status_val;
            ADR_CTRL:   rd_val = ctrl_val;
            default:    rd_val = 8'h00;
        endcase
    end

    // Input conditioning: 2-flop synchronizers plus one history stage for
    // edge detection on sck and ss_n.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_reg <= SYNC_IDLE;
            sync2_reg <= SYNC_IDLE;
            sck_d_reg <= 1'b0;
            ss_d_reg  <= 1'b1;
        end else begin
            sync1_reg <= {mosi_i, ss_n_i, sck_i};
            sync2_reg <= sync1_reg;
            sck_d_reg <= sync2_reg[0];
            ss_d_reg  <= sync2_reg[1];
        end
    end

    // Wishbone side and register file. Statement order sets priorities:
    // an RXDATA read and a same-cycle completion leave rx_full set, a
    // same-cycle TXDATA write wins over the load's clear, set beats W1C.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o     <= 1'b0;
            wb_dat_o     <= 8'h00;
            inta_o       <= 1'b0;
            rxdata_reg   <= 8'h00;
            txdata_reg   <= 8'h00;
            rx_full_reg  <= 1'b0;
            tx_full_reg  <= 1'b0;
            overrun_reg  <= 1'b0;
            underrun_reg <= 1'b0;
            cpha_reg     <= 1'b0;
            cpol_reg     <= 1'b0;
            en_reg       <= 1'b0;
            rx_ie_reg    <= 1'b0;
            tx_ie_reg    <= 1'b0;
        end else begin
            wb_ack_o <= wb_req;
            wb_dat_o <= (wb_req && !wb_we_i) ? rd_val : 8'h00;
            if (rd_rx) rx_full_reg <= 1'b0;
            if (wr_status) begin
                if (wb_dat_i[2]) overrun_reg  <= 1'b0;
                if (wb_dat_i[3]) underrun_reg <= 1'b0;
            end
            if (wr_ctrl) begin
                en_reg    <= wb_dat_i[2];
                rx_ie_reg <= wb_dat_i[3];
                tx_ie_reg <= wb_dat_i[4];
                // Mode is frozen for the duration of a frame.
                if (state_reg != ST_ACTIVE) begin
                    cpha_reg <= wb_dat_i[0];
                    cpol_reg <= wb_dat_i[1];
                end
            end
            if (byte_done) begin
                if (rx_full_reg && !rd_rx) begin
                    overrun_reg <= 1'b1;
                end else begin
                    rxdata_reg  <= rx_byte;
                    rx_full_reg <= 1'b1;
                end
            end
            if (tx_load) begin
                if (tx_full_reg) tx_full_reg  <= 1'b0;
                else             underrun_reg <= 1'b1;
            end
            if (wr_tx) begin
                txdata_reg  <= wb_dat_i;
                tx_full_reg <= 1'b1;
            end
            inta_o <= (rx_ie_reg && rx_full_reg) || (tx_ie_reg && en_reg && !tx_full_reg);
        end
    end

    // Transfer FSM: shift registers, bit counter and MISO drive.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg        <= ST_IDLE;
            bit_cnt_reg      <= 3'd0;
            load_pending_reg <= 1'b0;
            rx_shift_reg     <= 8'h00;
            tx_shift_reg     <= 8'h00;
            miso_o           <= 1'b0;
            miso_oe          <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    miso_o  <= 1'b0;
                    miso_oe <= 1'b0;
                    if (start) begin
                        state_reg        <= ST_ACTIVE;
                        miso_oe          <= 1'b1;
                        bit_cnt_reg      <= 3'd0;
                        load_pending_reg <= 1'b0;
                        rx_shift_reg     <= 8'h00;
                        if (cpha_reg) begin
                            // bit7 appears on the first leading edge.
                            tx_shift_reg <= tx_src;
                        end else begin
                            miso_o       <= tx_src[7];
                            tx_shift_reg <= {tx_src[6:0], 1'b0};
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!frame_ok) begin
                        // Deselect or disable drops any partial byte.
                        state_reg        <= ST_IDLE;
                        miso_o           <= 1'b0;
                        miso_oe          <= 1'b0;
                        bit_cnt_reg      <= 3'd0;
                        load_pending_reg <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift_reg <= rx_byte;
                            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) load_pending_reg <= 1'b1;
                        end
                        if (shift_edge) begin
                            if (load_pending_reg) begin
                                miso_o           <= tx_src[7];
                                tx_shift_reg     <= {tx_src[6:0], 1'b0};
                                load_pending_reg <= 1'b0;
                            end else begin
                                miso_o       <= tx_shift_reg[7];
                                tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                            end
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
